// File: rtl/gsensor_spi_responder_if.sv
// 3-wire SPI pin bundle between the gsensor master and the responder.
// The data pin is resolved outside: o_sdio is only meaningful while o_sdio_oe is high.
interface gsensor_spi_responder_if;
    logic i_spi_clk;
    logic i_cs_n;
    logic i_sdio;
    logic o_sdio;
    logic o_sdio_oe;

    modport master (
        output i_spi_clk, i_cs_n, i_sdio,
        input  o_sdio, o_sdio_oe
    );

    modport slave (
        input  i_spi_clk, i_cs_n, i_sdio,
        output o_sdio, o_sdio_oe
    );
endinterface

// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 accelerometer stand-in: 64x8 register file reached over a 3-wire link,
// with axis samples loaded from a parallel port and held off while a transfer is open.
module gsensor_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_VAL   = 8'hE5
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    gsensor_spi_responder_if.slave        spi,
    input  logic                          i_smp_valid,
    input  logic [47:0]                   i_smp_data,
    // o_reg_wr_valid is a single-cycle, unthrottled notification: addr/data are
    // valid only in that cycle and there is no ready, so a listener must take it.
    output logic                          o_reg_wr_valid,
    output logic [5:0]                    o_reg_wr_addr,
    output logic [7:0]                    o_reg_wr_data,
    output logic                          o_busy,
    output logic [2:0]                    o_dbg_state
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WR, S_RD, S_IGNORE} state_t;

    localparam logic [5:0] SMP_BASE = 6'h32;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, sdi_sync;
    logic sclk_s, csn_s, sdi_s, sclk_d, csn_d;
    logic sclk_rise, sclk_fall, cs_fall;

    logic [3:0] bit_cnt, bit_cnt_n;
    logic [6:0] sh_reg, sh_n;
    logic [5:0] addr, addr_n, addr_inc;
    logic       mb, mb_n;
    logic [7:0] out_sr, out_n;
    logic       oe_q, oe_n;
    logic       spi_wr;
    logic [7:0] rx_byte;

    logic [7:0]  regs [64];
    logic [47:0] pend;
    logic        pend_v, pend_apply;

    function automatic logic is_writable(input logic [5:0] a);
        return (a != 6'h00) && !(a >= 6'h32 && a <= 6'h37);
    endfunction

    // Clock and chip-select idle high, so their chains reset high to avoid false edges.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_sync <= '1;
            csn_sync  <= '1;
            sdi_sync  <= '0;
            sclk_d    <= 1'b1;
            csn_d     <= 1'b1;
        end else begin
            sclk_sync[0] <= spi.i_spi_clk;
            csn_sync[0]  <= spi.i_cs_n;
            sdi_sync[0]  <= spi.i_sdio;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                csn_sync[i]  <= csn_sync[i-1];
                sdi_sync[i]  <= sdi_sync[i-1];
            end
            sclk_d <= sclk_s;
            csn_d  <= csn_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~csn_s & csn_d;
    assign o_busy    = ~csn_s;
    assign rx_byte   = {sh_reg, sdi_s};
    assign addr_inc  = addr + 6'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        sh_n      = sh_reg;
        addr_n    = addr;
        mb_n      = mb;
        out_n     = out_sr;
        oe_n      = oe_q;
        spi_wr    = 1'b0;
        case (state)
            S_IDLE: begin
                bit_cnt_n = '0;
                sh_n      = '0;
                out_n     = '0;
                oe_n      = 1'b0;
                if (cs_fall) state_n = S_CMD;
            end
            S_CMD: if (sclk_rise) begin
                sh_n      = rx_byte[6:0];
                bit_cnt_n = bit_cnt + 4'd1;
                if (bit_cnt == 4'd7) begin
                    bit_cnt_n = '0;
                    mb_n      = rx_byte[6];
                    addr_n    = rx_byte[5:0];
                    state_n   = rx_byte[7] ? S_RD : S_WR;
                end
            end
            S_WR: if (sclk_rise) begin
                sh_n      = rx_byte[6:0];
                bit_cnt_n = bit_cnt + 4'd1;
                if (bit_cnt == 4'd7) begin
                    bit_cnt_n = '0;
                    spi_wr    = is_writable(addr);
                    if (mb) addr_n  = addr_inc;
                    else    state_n = S_IGNORE;
                end
            end
            // bit_cnt counts bits already driven; 0 means the first byte is not loaded yet.
            S_RD: if (sclk_fall) begin
                if (bit_cnt == 4'd0) begin
                    out_n     = regs[addr];
                    oe_n      = 1'b1;
                    bit_cnt_n = 4'd1;
                end else if (bit_cnt < 4'd8) begin
                    out_n     = {out_sr[6:0], 1'b0};
                    bit_cnt_n = bit_cnt + 4'd1;
                end else if (mb) begin
                    addr_n    = addr_inc;
                    out_n     = regs[addr_inc];
                    bit_cnt_n = 4'd1;
                end else begin
                    out_n   = '0;
                    oe_n    = 1'b0;
                    state_n = S_IGNORE;
                end
            end
            S_IGNORE: begin
                out_n = '0;
                oe_n  = 1'b0;
            end
            default: state_n = S_IDLE;
        endcase
        // Chip select released: abandon whatever was in flight, partial byte included.
        if (state != S_IDLE && csn_s) begin
            state_n = S_IDLE;
            out_n   = '0;
            oe_n    = 1'b0;
            spi_wr  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt        <= '0;
            sh_reg         <= '0;
            addr           <= '0;
            mb             <= 1'b0;
            out_sr         <= '0;
            oe_q           <= 1'b0;
            o_reg_wr_valid <= 1'b0;
            o_reg_wr_addr  <= '0;
            o_reg_wr_data  <= '0;
        end else begin
            bit_cnt        <= bit_cnt_n;
            sh_reg         <= sh_n;
            addr           <= addr_n;
            mb             <= mb_n;
            out_sr         <= out_n;
            oe_q           <= oe_n;
            o_reg_wr_valid <= spi_wr;
            if (spi_wr) begin
                o_reg_wr_addr <= addr;
                o_reg_wr_data <= rx_byte;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend   <= '0;
            pend_v <= 1'b0;
        end else if (i_smp_valid && o_busy) begin
            pend   <= i_smp_data;
            pend_v <= 1'b1;
        end else if (pend_apply) begin
            pend_v <= 1'b0;
        end
    end

    assign pend_apply = pend_v && !o_busy;

    // A fresh idle-time sample is written last so it overrides a pending one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
            regs[6'h00] <= DEVID_VAL;
            regs[6'h2C] <= 8'h0A;
        end else begin
            if (spi_wr) regs[addr] <= rx_byte;
            if (pend_apply)
                for (int i = 0; i < 6; i++) regs[SMP_BASE + 6'(i)] <= pend[8*i +: 8];
            if (i_smp_valid && !o_busy)
                for (int i = 0; i < 6; i++) regs[SMP_BASE + 6'(i)] <= i_smp_data[8*i +: 8];
        end
    end

    assign spi.o_sdio    = out_sr[7];
    assign spi.o_sdio_oe = oe_q;
    assign o_dbg_state   = state;
endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Bench for gsensor_spi_responder: a mode-3 master driven by tasks, checked against
// a register-map model that applies the read/write/burst/sample rules directly.
module tb_gsensor_spi_responder;
    localparam int HALF = 8;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_smp_valid;
    logic [47:0] i_smp_data;
    logic        o_reg_wr_valid;
    logic [5:0]  o_reg_wr_addr;
    logic [7:0]  o_reg_wr_data;
    logic        o_busy;
    logic [2:0]  o_dbg_state;

    gsensor_spi_responder_if spi ();

    gsensor_spi_responder dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .spi            (spi.slave),
        .i_smp_valid    (i_smp_valid),
        .i_smp_data     (i_smp_data),
        .o_reg_wr_valid (o_reg_wr_valid),
        .o_reg_wr_addr  (o_reg_wr_addr),
        .o_reg_wr_data  (o_reg_wr_data),
        .o_busy         (o_busy),
        .o_dbg_state    (o_dbg_state)
    );

    always #10 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    logic [13:0] exp_q[$];
    logic [13:0] got_q[$];
    logic [7:0]  model_regs[64];
    logic [47:0] model_pend;
    bit          model_pend_v;
    logic [7:0]  tx_data[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge i_clk)
        if (!i_rst && o_reg_wr_valid) got_q.push_back({o_reg_wr_addr, o_reg_wr_data});

    task automatic wait_clk(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_regs[i] = 8'h00;
        model_regs[0]     = 8'hE5;
        model_regs[6'h2C] = 8'h0A;
        model_pend_v      = 1'b0;
    endtask

    function automatic bit model_writable(input logic [5:0] a);
        return (a != 6'h00) && !(a >= 6'h32 && a <= 6'h37);
    endfunction

    task automatic model_load(input logic [47:0] d);
        for (int i = 0; i < 6; i++) model_regs[6'h32 + i] = d[8*i +: 8];
    endtask

    task automatic pulse_sample(input logic [47:0] d);
        i_smp_valid = 1'b1;
        i_smp_data  = d;
        wait_clk(1);
        i_smp_valid = 1'b0;
        if (spi.i_cs_n == 1'b0) begin
            model_pend   = d;
            model_pend_v = 1'b1;
        end else begin
            model_load(d);
        end
    endtask

    task automatic cs_begin();
        spi.i_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end();
        spi.i_spi_clk = 1'b1;
        wait_clk(HALF);
        spi.i_cs_n = 1'b1;
        wait_clk(HALF);
        if (model_pend_v) begin
            model_load(model_pend);
            model_pend_v = 1'b0;
        end
        check("oe_after_cs", spi.o_sdio_oe, 1'b0);
        check("busy_after_cs", o_busy, 1'b0);
    endtask

    // Mode 3: master changes data on the falling edge and samples on the rising edge.
    task automatic byte_xfer(input logic [7:0] tx, input bit drive, input int nbits,
                             output logic [7:0] rx, output bit oe_all);
        rx = '0;
        oe_all = 1'b1;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi.i_spi_clk = 1'b0;
            spi.i_sdio    = drive ? tx[i] : 1'b0;
            wait_clk(HALF);
            spi.i_spi_clk = 1'b1;
            rx[i]  = spi.o_sdio;
            oe_all = oe_all & spi.o_sdio_oe;
            wait_clk(HALF);
        end
    endtask

    task automatic do_transfer(input logic [7:0] cmd, input int n, input int abort_bits,
                               input int smp_at, input logic [47:0] smp);
        logic [5:0] a;
        logic [7:0] rx;
        bit oe_all, wr_live;
        int nb;
        a = cmd[5:0];
        wr_live = 1'b1;
        cs_begin();
        byte_xfer(cmd, 1'b1, 8, rx, oe_all);
        for (int b = 0; b < n; b++) begin
            if (smp_at == b) pulse_sample(smp);
            if (cmd[7]) begin
                byte_xfer(8'h00, 1'b0, 8, rx, oe_all);
                check("rd_data", rx, model_regs[a]);
                check("rd_oe", oe_all, 1'b1);
                a = a + 6'd1;
            end else begin
                nb = (abort_bits != 0 && b == n - 1) ? abort_bits : 8;
                byte_xfer(tx_data[b], 1'b1, nb, rx, oe_all);
                if (nb == 8 && wr_live) begin
                    if (model_writable(a)) begin
                        model_regs[a] = tx_data[b];
                        exp_q.push_back({a, tx_data[b]});
                    end
                    if (cmd[6]) a = a + 6'd1;
                    else        wr_live = 1'b0;
                end
            end
        end
        cs_end();
        check("wr_pulse_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check("wr_pulse", got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  cmd, rx;
        logic [47:0] smp;
        bit oe_all;
        int n, ab, sat;

        i_rst = 1'b1;
        spi.i_spi_clk = 1'b1;
        spi.i_cs_n    = 1'b1;
        spi.i_sdio    = 1'b0;
        i_smp_valid   = 1'b0;
        i_smp_data    = '0;
        model_reset();
        wait_clk(4);
        i_rst = 1'b0;
        wait_clk(2);

        check("rst_sdio", spi.o_sdio, 1'b0);
        check("rst_oe", spi.o_sdio_oe, 1'b0);
        check("rst_wr_valid", o_reg_wr_valid, 1'b0);
        check("rst_wr_addr", o_reg_wr_addr, 6'h00);
        check("rst_wr_data", o_reg_wr_data, 8'h00);
        check("rst_busy", o_busy, 1'b0);
        check("rst_state", o_dbg_state, 3'd0);

        // Device ID read, then a reset applied while a read byte is being shifted.
        do_transfer(8'h80, 1, 0, -1, '0);
        cs_begin();
        byte_xfer(8'h80, 1'b1, 8, rx, oe_all);
        byte_xfer(8'h00, 1'b0, 3, rx, oe_all);
        check("mid_rd_oe", oe_all, 1'b1);
        i_rst = 1'b1;
        spi.i_cs_n = 1'b1;
        wait_clk(1);
        check("mid_rst_oe", spi.o_sdio_oe, 1'b0);
        check("mid_rst_state", o_dbg_state, 3'd0);
        check("mid_rst_busy", o_busy, 1'b0);
        i_rst = 1'b0;
        model_reset();
        got_q.delete();
        wait_clk(HALF);

        tx_data[0] = 8'h08;
        do_transfer(8'h2D, 1, 0, -1, '0);
        do_transfer(8'hAD, 1, 0, -1, '0);
        do_transfer(8'hAC, 1, 0, -1, '0);
        check("model_2d", model_regs[6'h2D], 8'h08);

        pulse_sample(48'h0302_0100_FFFE);
        wait_clk(2);
        do_transfer(8'hF2, 6, 0, 2, 48'h1111_1111_1111);
        do_transfer(8'hF2, 6, 0, -1, '0);

        tx_data[0] = 8'hAA;
        tx_data[1] = 8'hBB;
        do_transfer(8'h7F, 2, 0, -1, '0);
        do_transfer(8'hBF, 1, 0, -1, '0);
        do_transfer(8'h80, 1, 0, -1, '0);

        tx_data[0] = 8'h5C;
        do_transfer(8'h2D, 1, 4, -1, '0);
        check("abort_state", o_dbg_state, 3'd0);
        do_transfer(8'hAD, 1, 0, -1, '0);

        for (int t = 0; t < 40; t++) begin
            cmd = 8'($urandom);
            if (cmd[7]) n = cmd[6] ? $urandom_range(1, 4) : 1;
            else        n = $urandom_range(1, cmd[6] ? 4 : 2);
            ab  = (!cmd[7] && $urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            sat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            smp = {16'($urandom), 32'($urandom)};
            for (int i = 0; i < 8; i++) tx_data[i] = 8'($urandom);
            do_transfer(cmd, n, ab, sat, smp);
            if ($urandom_range(0, 3) == 0) begin
                pulse_sample({16'($urandom), 32'($urandom)});
                wait_clk(2);
            end
        end
        do_transfer(8'hF2, 6, 0, -1, '0);

        wait_clk(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
